palette_lut: RTL

- Programmable colour palette: maps an INDEX_W-bit pixel index to r/g/b channels of CH_W bits each. Sits between the framebuffer fetch and the video DAC/sync output stage.
- Replaces a fixed combinational colour table with a CPU-writable RAM and a registered 2-cycle pipeline.
- Adds a blanking override and a self-initialising default palette after reset.

---
 rtl/palette_lut.sv | 99 +++++++++
 1 files changed

// File: rtl/palette_lut.sv
// palette_lut: CPU-writable colour palette, grey-ramp self-init after reset, 2-cycle lookup with blanking.
// Define PALETTE_SHADOW_EN for double-buffered banks swapped on frame_start after a commit.
module palette_lut #(
  parameter int INDEX_W = 8,
  parameter int CH_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic                 blank,
  output logic                 rgb_valid,
  output logic [CH_W-1:0]      r,
  output logic [CH_W-1:0]      g,
  output logic [CH_W-1:0]      b,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]    wr_data,
  output logic                 wr_ready,
  output logic                 busy,
  input  logic                 commit,
  input  logic                 frame_start
);
  localparam int DEPTH = 2**INDEX_W;
  localparam int EW    = 3*CH_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [INDEX_W-1:0] cnt;
  logic [CH_W-1:0] d;
  logic ram_we;
  logic [INDEX_W-1:0] ram_addr;
  logic [EW-1:0] ram_data, rd_data, rd_q, rgb;
  logic v1, z1;
  assign d        = cnt[INDEX_W-1 -: CH_W];
  assign busy     = state == INIT;
  assign wr_ready = state == RUN;
  assign ram_we   = busy | (wr_en & wr_ready);
  assign ram_addr = busy ? cnt : wr_addr;
  assign ram_data = busy ? {d, d, d} : wr_data;
  assign {r, g, b} = rgb;
  always_comb begin
    state_nxt = (state == INIT && &cnt) ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= busy ? cnt + 1'b1 : cnt;
    end
  end
`ifdef PALETTE_SHADOW_EN
  logic [EW-1:0] mem0 [DEPTH];
  logic [EW-1:0] mem1 [DEPTH];
  logic act, pending;
  // Bank !act is the shadow; INIT fills both so either can become active.
  always_ff @(posedge clk) begin
    if (ram_we && (busy || act))  mem0[ram_addr] <= ram_data;
    if (ram_we && (busy || !act)) mem1[ram_addr] <= ram_data;
  end
  assign rd_data = act ? mem1[pix_index] : mem0[pix_index];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= 1'b0;
      pending <= 1'b0;
    end else if (frame_start && (pending || commit)) begin
      act     <= ~act;
      pending <= 1'b0;
    end else if (commit) begin
      pending <= 1'b1;
    end
  end
`else
  logic [EW-1:0] mem [DEPTH];
  logic unused_shadow;
  assign unused_shadow = commit ^ frame_start;
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
  end
  assign rd_data = mem[pix_index];
`endif
  // The read is sampled before the same-edge write lands, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= '0;
      v1        <= 1'b0;
      z1        <= 1'b0;
      rgb_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      rd_q      <= rd_data;
      v1        <= pix_valid;
      z1        <= blank | busy;
      rgb_valid <= v1;
      rgb       <= (v1 && !z1) ? rd_q : '0;
    end
  end
endmodule
